// File: rtl/branch_resolve_pkg.sv
// Shared encodings for branch resolution: funct3 conditions, op kinds,
// compare-result bit positions and the redirect FSM states.
package branch_resolve_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam int unsigned F3_W          = 3;
  localparam int unsigned CMP_W         = 3;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    OP_BRANCH = 2'b00,
    OP_JAL    = 2'b01,
    OP_JALR   = 2'b10,
    OP_RSVD   = 2'b11
  } op_kind_e;

  // Bit positions inside the comparator's {EQ, SL, UL} result
  localparam int unsigned CMP_EQ = 2;
  localparam int unsigned CMP_SL = 1;
  localparam int unsigned CMP_UL = 0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_cond.sv
// Branch condition decode: turns op kind, funct3 and compare flags into
// a taken decision plus a reserved-encoding flag.
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [1:0]       op_kind,
  input  logic [F3_W-1:0]  funct3,
  input  logic [CMP_W-1:0] cmp_result,
  output logic             taken_c,
  output logic             illegal_c
);

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (op_kind_e'(op_kind))
      OP_BRANCH: begin
        case (funct3)
          F3_BEQ:  taken_c = cmp_result[CMP_EQ];
          F3_BNE:  taken_c = ~cmp_result[CMP_EQ];
          F3_BLT:  taken_c = cmp_result[CMP_SL];
          F3_BGE:  taken_c = ~cmp_result[CMP_SL];
          F3_BLTU: taken_c = cmp_result[CMP_UL];
          F3_BGEU: taken_c = ~cmp_result[CMP_UL];
          default: illegal_c = 1'b1;
        endcase
      end
      OP_JAL:  taken_c = 1'b1;
      OP_JALR: taken_c = 1'b1;
      OP_RSVD: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves control-flow ops from execute: computes the real next PC, checks
// the front-end prediction, holds a redirect to fetch and updates counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_kind,
  input  logic [F3_W-1:0]  funct3,
  input  logic [CMP_W-1:0] cmp_result,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             flush,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic [XLEN-1:0]  upd_pc,
  output logic [XLEN-1:0]  upd_target,
  output logic             illegal,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic              taken_c, illegal_c;
  logic              accept_c, mispredict_c;
  logic [XLEN-1:0]   seq_pc_c, br_target_c, jalr_sum_c, target_c, next_pc_c;
  logic [XLEN-1:0]   redirect_pc_d;
  logic [CNT_W-1:0]  mispred_d;

  branch_cond u_cond (
    .op_kind    (op_kind),
    .funct3     (funct3),
    .cmp_result (cmp_result),
    .taken_c    (taken_c),
    .illegal_c  (illegal_c)
  );

  // Target arithmetic; all sums wrap modulo 2^XLEN
  assign seq_pc_c    = pc + XLEN'(4);
  assign br_target_c = pc + imm;
  assign jalr_sum_c  = rs1 + imm;
  assign target_c    = (op_kind_e'(op_kind) == OP_JALR) ? {jalr_sum_c[XLEN-1:1], 1'b0}
                                                        : br_target_c;
  assign next_pc_c   = taken_c ? target_c : seq_pc_c;

  // Target only matters when the op is actually taken
  assign mispredict_c = (pred_taken != taken_c) | (taken_c & (pred_target != target_c));

  assign redirect_valid = (state_q == HOLD);
  assign in_ready       = ~rst & ~redirect_valid & ~flush;
  assign accept_c       = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc;
    mispred_d     = mispred_count;
    case (state_q)
      IDLE: begin
        if (accept_c && mispredict_c) begin
          state_d       = HOLD;
          redirect_pc_d = next_pc_c;
          mispred_d     = sat_inc(mispred_count);
        end
      end
      HOLD: begin
        if (flush || redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Redirect payload, predictor update record and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc   <= '0;
      mispred_count <= '0;
      br_count      <= '0;
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      upd_pc        <= '0;
      upd_target    <= '0;
      illegal       <= 1'b0;
    end else begin
      redirect_pc   <= redirect_pc_d;
      mispred_count <= mispred_d;
      upd_valid     <= accept_c;
      illegal       <= accept_c & illegal_c;
      if (accept_c) begin
        upd_taken  <= taken_c;
        upd_pc     <= pc;
        upd_target <= target_c;
        br_count   <= sat_inc(br_count);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected update records are queued at
// drive time and compared when the DUT raises upd_valid.
module tb_branch_resolve;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op_kind;
  logic [2:0]       funct3;
  logic [2:0]       cmp_result;
  logic [XLEN-1:0]  pc, imm, rs1, pred_target;
  logic             pred_taken;
  logic             flush;
  logic             redirect_valid, redirect_ready;
  logic [XLEN-1:0]  redirect_pc;
  logic             upd_valid, upd_taken, illegal;
  logic [XLEN-1:0]  upd_pc, upd_target;
  logic [CNT_W-1:0] br_count, mispred_count;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_kind(op_kind), .funct3(funct3), .cmp_result(cmp_result),
    .pc(pc), .imm(imm), .rs1(rs1), .pred_taken(pred_taken),
    .pred_target(pred_target), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_taken(upd_taken),
    .upd_pc(upd_pc), .upd_target(upd_target), .illegal(illegal),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  typedef struct {
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] next;
    logic        illegal;
    logic        mis;
  } exp_t;

  exp_t             sb[$];
  int               n_pass = 0;
  int               n_checks = 0;
  logic [CNT_W-1:0] br_model = '0;
  logic [CNT_W-1:0] mis_model = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                 input logic [2:0] cmp, input logic [31:0] p,
                                 input logic [31:0] im, input logic [31:0] r1,
                                 input logic pt, input logic [31:0] ptg);
    exp_t e;
    logic eq, sl, ul;
    eq = cmp[2]; sl = cmp[1]; ul = cmp[0];
    e.pc = p; e.taken = 1'b0; e.illegal = 1'b0;
    if (op == 2'd0) begin
      case (f3)
        3'd0: e.taken = eq;
        3'd1: e.taken = !eq;
        3'd4: e.taken = sl;
        3'd5: e.taken = !sl;
        3'd6: e.taken = ul;
        3'd7: e.taken = !ul;
        default: e.illegal = 1'b1;
      endcase
    end else if (op == 2'd3) begin
      e.illegal = 1'b1;
    end else begin
      e.taken = 1'b1;
    end
    e.target = (op == 2'd2) ? ((r1 + im) & 32'hFFFF_FFFE) : (p + im);
    e.next   = e.taken ? e.target : p + 32'd4;
    e.mis    = (pt != e.taken) || (e.taken && (ptg != e.target));
    return e;
  endfunction

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [2:0] cmp,
                      input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                      input logic pt, input logic [31:0] ptg, output logic mis);
    exp_t e;
    @(negedge clk); #1;
    check("send_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op_kind = op; funct3 = f3; cmp_result = cmp;
    pc = p; imm = im; rs1 = r1; pred_taken = pt; pred_target = ptg;
    e = model(op, f3, cmp, p, im, r1, pt, ptg);
    sb.push_back(e);
    br_model = sat(br_model);
    if (e.mis) mis_model = sat(mis_model);
    mis = e.mis;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_redirect();
    @(negedge clk); #1;
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    @(negedge clk);
    check("release_valid", {31'd0, redirect_valid}, 32'd0);
    check("release_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_rv"}, {31'd0, redirect_valid}, 32'd0);
    check({tag, "_rpc"}, redirect_pc, 32'd0);
    check({tag, "_uv"}, {31'd0, upd_valid}, 32'd0);
    check({tag, "_ut"}, {31'd0, upd_taken}, 32'd0);
    check({tag, "_upc"}, upd_pc, 32'd0);
    check({tag, "_utgt"}, upd_target, 32'd0);
    check({tag, "_ill"}, {31'd0, illegal}, 32'd0);
    check({tag, "_br"}, 32'(br_count), 32'd0);
    check({tag, "_mis"}, 32'(mispred_count), 32'd0);
  endtask

  // Scoreboard consumer: one queued record per upd_valid pulse
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && upd_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
        check("upd_pc", upd_pc, e.pc);
        check("upd_target", upd_target, e.target);
        check("illegal", {31'd0, illegal}, {31'd0, e.illegal});
        check("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.mis});
        if (e.mis) check("redirect_pc", redirect_pc, e.next);
        check("in_ready", {31'd0, in_ready}, {31'd0, !e.mis});
        check("br_count", 32'(br_count), 32'(br_model));
        check("mispred_count", 32'(mispred_count), 32'(mis_model));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        mis;
    logic [31:0] rp, ri, rr, rt;
    logic [11:0] r12;
    logic [1:0]  rop;
    logic [2:0]  rf3, rcmp;
    logic        rpt;
    exp_t        pe;

    rst = 1'b1; in_valid = 1'b0; op_kind = '0; funct3 = '0; cmp_result = '0;
    pc = '0; imm = '0; rs1 = '0; pred_taken = 1'b0; pred_target = '0;
    flush = 1'b0; redirect_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #1 rst = 1'b0;
    #1 check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // BEQ taken, predicted not-taken
    send(2'd0, 3'b000, 3'b100, 32'h1000, 32'h40, 32'h0, 1'b0, 32'h0, mis);
    release_redirect();

    // BLTU not taken, predicted taken; redirect held while fetch stalls
    send(2'd0, 3'b110, 3'b000, 32'h2000, 32'h100, 32'h0, 1'b1, 32'h2100, mis);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, redirect_valid}, 32'd1);
      check("hold_pc", redirect_pc, 32'h2004);
    end
    release_redirect();

    // JALR correctly predicted, bit0 cleared
    send(2'd2, 3'b000, 3'b000, 32'h3800, 32'h10, 32'h3001, 1'b1, 32'h3010, mis);
    @(negedge clk);

    // Reserved funct3: illegal pulse only
    send(2'd0, 3'b010, 3'b111, 32'h4000, 32'h8, 32'h0, 1'b0, 32'h1234, mis);
    @(negedge clk);
    @(negedge clk);
    check("illegal_drop", {31'd0, illegal}, 32'd0);
    check("upd_valid_drop", {31'd0, upd_valid}, 32'd0);

    // Flush while holding a redirect, with a competing input
    send(2'd0, 3'b001, 3'b100, 32'h5000, 32'h20, 32'h0, 1'b1, 32'h5020, mis);
    @(negedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; op_kind = 2'd1; pc = 32'h6000; imm = 32'h4;
    #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_rv", {31'd0, redirect_valid}, 32'd0);
    check("flush_uv", {31'd0, upd_valid}, 32'd0);
    check("flush_br", 32'(br_count), 32'(br_model));
    check("flush_ready", {31'd0, in_ready}, 32'd1);

    // Random mix of ops and predictions
    for (int n = 0; n < 24; n++) begin
      rop  = 2'($urandom_range(0, 3));
      rf3  = 3'($urandom_range(0, 7));
      rcmp = 3'($urandom_range(0, 7));
      rp   = $urandom & 32'hFFFF_FFFC;
      r12  = 12'($urandom_range(0, 4095));
      ri   = {{20{r12[11]}}, r12};
      rr   = $urandom;
      rpt  = 1'($urandom_range(0, 1));
      pe   = model(rop, rf3, rcmp, rp, ri, rr, 1'b0, 32'h0);
      rt   = ($urandom_range(0, 1) == 1) ? pe.target : $urandom;
      send(rop, rf3, rcmp, rp, ri, rr, rpt, rt, mis);
      if (mis) release_redirect();
      else @(negedge clk);
    end

    // Fresh start, then drive the 4-bit branch counter past saturation
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    br_model = '0; mis_model = '0;
    for (int n = 0; n < 17; n++) begin
      rp = 32'h8000 + 32'(n * 16);
      send(2'd1, 3'b000, 3'b000, rp, 32'h100, 32'h0, 1'b1, rp + 32'h100, mis);
    end
    @(negedge clk);
    check("br_saturated", 32'(br_count), 32'h0000_000F);

    // Reset in the middle of a held redirect
    send(2'd1, 3'b000, 3'b000, 32'h9000, 32'h80, 32'h0, 1'b0, 32'h0, mis);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("rst_hold");
    #1 rst = 1'b0;
    br_model = '0; mis_model = '0;
    @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
